// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (this transmitter and the receiver).
//   uart_tx_state_t : transmitter FSM state encoding
//   UART_DATA_BITS  : data bits per character
//   UART_IDLE_LEVEL : line level while idle / during stop bits
//   UART_CLK_DIV    : default clocks per bit (100 MHz / 115200)
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_CLK_DIV    = 868;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. While en is high a counter runs 0..CLK_DIV-1 and wraps;
// bit_end pulses for the one cycle in which the counter sits at CLK_DIV-1.
// The counter is held at 0 while en is low, so it restarts cleanly when en
// rises and the first bit_end comes exactly CLK_DIV cycles later.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-low reset
//   en      in  run the timer
//   bit_end out one-cycle pulse at the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLK_DIV = uart_pkg::UART_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
// Sends one NBYTES-byte word per handshake as back-to-back 8N1 characters,
// least-significant byte first. Byte k carries tx_word[8k+7:8k].
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit (11 bit times per byte instead of 10).
//
// Handshake: a word is accepted on a rising clk edge where tx_valid && tx_ready.
// tx_word is sampled only at that edge; tx_valid/tx_word are ignored while
// busy. tx_ready is high only in IDLE, including the tx_done cycle, so a word
// held valid across the end of a frame is taken one edge after the last stop
// bit ends.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tx_word   in   word to send (8*NBYTES bits)
//   tx_valid  in   producer has a word
//   tx_ready  out  block can accept a word
//   tx        out  serial line, idles high, driven from a flop
//   tx_busy   out  frame in progress (!tx_ready)
//   tx_done   out  one-cycle pulse after the last stop bit of the word
//   dbg_state out  current FSM state
// -----------------------------------------------------------------------------
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV,
  parameter int NBYTES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*NBYTES-1:0]   tx_word,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done,
  output uart_tx_state_t        dbg_state
);

  localparam int               W         = 8 * NBYTES;
  localparam int               BIW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIW-1:0]   LAST_BYTE = BIW'(NBYTES - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t  state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [2:0]      bit_q,   bit_d;
  logic [BIW-1:0]  byte_q,  byte_d;
  logic            tx_q,    tx_d;
  logic            done_q,  done_d;

  logic            bit_end;
  logic            accept;

  assign tx_ready  = (state_q == ST_IDLE);
  assign tx_busy   = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

  // The timer runs for the whole word; it wraps across byte boundaries so
  // consecutive characters follow with no gap.
  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != ST_IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    tx_d    = UART_IDLE_LEVEL;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = tx_word;
          byte_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (byte_q < LAST_BYTE) begin
            byte_d  = byte_q + 1'b1;
            shift_d = shift_q >> UART_DATA_BITS;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line level is decoded from the state being entered, so tx changes
    // on the same edge as the state and comes straight out of a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^shift_d[7:0];
`endif
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
`timescale 1ns/1ps
module tb_uart_word_tx;
  import uart_pkg::*;

  localparam int D  = 4;
  localparam int NB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int B = 11;
`else
  localparam int B = 10;
`endif
  localparam int FRAME      = NB * B * D;
  localparam int SLOW_D     = 868;
  localparam int SLOW_FRAME = B * SLOW_D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT: CLK_DIV=4, NBYTES=4 ----------------
  logic [31:0]    tx_word;
  logic           tx_valid, tx_ready, tx, tx_busy, tx_done;
  uart_tx_state_t dbg_state;

  uart_word_tx #(.CLK_DIV(D), .NBYTES(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_word   (tx_word),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .dbg_state (dbg_state)
  );

  // ---------------- DUT: default divider, NBYTES=1 ----------------
  logic [7:0]     s_word;
  logic           s_valid, s_ready, s_tx, s_busy, s_done;
  uart_tx_state_t s_state;

  uart_word_tx #(.NBYTES(1)) dut_slow (
    .clk       (clk),
    .reset     (reset),
    .tx_word   (s_word),
    .tx_valid  (s_valid),
    .tx_ready  (s_ready),
    .tx        (s_tx),
    .tx_busy   (s_busy),
    .tx_done   (s_done),
    .dbg_state (s_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          start_q[$];
  int          done_q[$];
  logic [NB-1:0] last_par;
  bit          mon_en = 1'b1;
  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  // Decodes a whole word from the line, checking every cycle of every bit.
  initial begin : monitor
    logic [31:0]   w, e;
    logic [NB-1:0] par;
    int            glitch;
    logic          first, v;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cyc);
        w = '0; par = '0; glitch = 0; first = 1'b0;
        for (int k = 0; k < NB; k++) begin
          for (int s = 0; s < B; s++) begin
            for (int c = 0; c < D; c++) begin
              if (k != 0 || s != 0 || c != 0) @(negedge clk);
              v = tx;
              if (c == 0) first = v;
              else if (v !== first) glitch++;
              if (c == 0) begin
                if (s == 0) begin
                  if (v !== 1'b0) glitch++;
                end else if (s <= 8) begin
                  w[8*k+s-1] = v;
                end else if (s == B - 1) begin
                  if (v !== 1'b1) glitch++;
                end else begin
                  par[k] = v;
                end
              end
            end
          end
        end
        @(negedge clk);
        chk("frame_shape", glitch, 0);
        chk("done_after_stop", tx_done, 1'b1);
        chk("idle_after_stop", tx, 1'b1);
        done_q.push_back(cyc);
        last_par = par;
        chk("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", w, e);
`ifdef UART_TX_PARITY_EN
          for (int k = 0; k < NB; k++) chk("parity", par[k], ^e[8*k +: 8]);
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w, output int acc);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_word  = w;
    for (int i = 0; i < 5000 && tx_ready !== 1'b1; i++) @(negedge clk);
    chk("ready_for_accept", tx_ready, 1'b1);
    exp_q.push_back(w);
    @(negedge clk);
    acc      = cyc;
    tx_valid = 1'b0;
    tx_word  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int acc, b0, d0, n_acc, target, low_seen, errs, sb;
    logic [10:0] fb;

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_word  = '0;
    s_valid  = 1'b0;
    s_word   = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      repeat (3) begin
        @(negedge clk);
        tx_valid = 1'($urandom_range(0, 1));
        tx_word  = $urandom;
        s_valid  = 1'($urandom_range(0, 1));
        s_word   = 8'($urandom);
      end
      #1;
      chk("reset_tx", tx, 1'b1);
      chk("reset_ready", tx_ready, 1'b1);
      chk("reset_busy", tx_busy, 1'b0);
      chk("reset_done", tx_done, 1'b0);
      chk("reset_state", dbg_state, ST_IDLE);
      chk("reset_slow_tx", s_tx, 1'b1);
    end

    // Release with tx_valid low: line must stay quiet.
    @(negedge clk);
    tx_valid = 1'b0;
    s_valid  = 1'b0;
    reset    = 1'b1;
    low_seen = 0;
    d0       = done_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_word = $urandom;
      if (tx !== 1'b1 || tx_busy !== 1'b0) low_seen++;
    end
    chk("quiet_after_reset", low_seen, 0);
    chk("no_done_when_idle", done_cnt - d0, 0);

    // Basic word.
    b0 = busy_cnt;
    d0 = done_cnt;
    send(32'h12345678, acc);
    wait_idle();
    chk("busy_cycles", busy_cnt - b0, FRAME);
    chk("done_count", done_cnt - d0, 1);
    chk("start_at_accept", start_q[$], acc);
    chk("done_latency", done_q[$] - acc, FRAME);

    // Back-to-back with tx_word changing every cycle.
    d0    = done_cnt;
    n_acc = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_word  = $urandom;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (tx_ready === 1'b1) begin
        exp_q.push_back(tx_word);
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 2) break;
      tx_word = $urandom;
    end
    tx_valid = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    wait_idle();
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_gap", start_q[$] - done_q[$-1], 1);

    // Reset during bit 3 of byte 2 (byte 2 = 0x00, so the line is low there).
    mon_en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_word  = 32'h11002233;
    @(negedge clk);
    tx_valid = 1'b0;
    acc      = cyc;
    d0       = done_cnt;
    target   = acc + (2 * B + 4) * D + 1;
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    chk("pre_reset_busy", tx_busy, 1'b1);
    chk("pre_reset_line", tx, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_ready", tx_ready, 1'b1);
    chk("async_reset_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", tx, 1'b1);
    mon_en = 1'b1;

    d0 = done_cnt;
    send(32'hA5A5A5A5, acc);
    wait_idle();
    chk("post_reset_done", done_cnt - d0, 1);

    // Mixed-byte word; with parity compiled in the parity bits are 0,0,1,0.
    b0 = busy_cnt;
    send(32'h000700FF, acc);
    wait_idle();
    chk("frame_len_000700ff", busy_cnt - b0, FRAME);
`ifdef UART_TX_PARITY_EN
    chk("parity_bits", last_par, 4'b0100);
`endif

    // Default divider, one byte.
    @(negedge clk);
    s_valid = 1'b1;
    s_word  = 8'h55;
    @(negedge clk);
    s_valid = 1'b0;
    s_word  = 8'hFF;
    fb = '1;
    fb[0] = 1'b0;
    fb[8:1] = 8'h55;
`ifdef UART_TX_PARITY_EN
    fb[9] = ^fb[8:1];
`endif
    errs = 0;
    sb   = 0;
    for (int i = 0; i < SLOW_FRAME; i++) begin
      if (s_tx !== fb[i / SLOW_D]) errs++;
      if (s_busy === 1'b1) sb++;
      if (s_done !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("slow_line", errs, 0);
    chk("slow_busy", sb, SLOW_FRAME);
    chk("slow_done", s_done, 1'b1);
    chk("slow_ready", s_ready, 1'b1);
    chk("slow_idle_line", s_tx, 1'b1);
    @(negedge clk);
    chk("slow_done_pulse", s_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
